// File: rtl/rx_pcs_pkg.sv
// ----------------------------------------------------------------------------
// rx_pcs_pkg
// Shared constants and types for the 64b/66b receive PCS blocks:
//   SH_DATA / SH_CTRL   - the two legal sync-header values
//   SCR_TAP_A/SCR_TAP_B - self-synchronous scrambler taps (x^58 + x^39 + 1)
//   asm_state_e         - block assembly FSM states
//   hdr_is_bad()        - flags the two illegal sync headers (00, 11)
// ----------------------------------------------------------------------------
package rx_pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } asm_state_e;

  function automatic logic hdr_is_bad(input logic [1:0] head);
    return (head != SH_DATA) && (head != SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_descrambler_64.sv
// ----------------------------------------------------------------------------
// pcs_descrambler_64
// 64-bit parallel self-synchronous descrambler, polynomial x^58 + x^39 + 1.
// Bit 0 of din is the first bit on the line.
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset; loads the state with all-ones
//   en   in   advance the state with the current din (one completed block)
//   din  in   64 scrambled bits
//   dout out  64 descrambled bits (combinational from din and state); equals
//             din when P_DESCRAMBLE_EN is 0
// The state always tracks the last 58 scrambled bits, even in bypass, so that
// the line history stays coherent whichever way the block is built.
// ----------------------------------------------------------------------------
module pcs_descrambler_64
  import rx_pcs_pkg::*;
#(
  parameter int P_DESCRAMBLE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  localparam int TAP_GAP = SCR_TAP_B - SCR_TAP_A;

  // s_q[57] is the most recent scrambled bit, s_q[0] the oldest.
  logic [SCR_TAP_B-1:0] s_q, s_d;

  // Line history seen by bit i: hist[i + SCR_TAP_B - k] is the bit k positions
  // earlier. Only din bits reachable by the SCR_TAP_A tap are included.
  logic [63-SCR_TAP_A+SCR_TAP_B:0] hist;
  logic [63:0]                     descr;

  always_comb begin
    hist  = {din[63-SCR_TAP_A:0], s_q};
    descr = '0;
    for (int i = 0; i < 64; i++) begin
      // hist[i + TAP_GAP] is s[i-39], hist[i] is s[i-58]
      descr[i] = din[i] ^ hist[i + TAP_GAP] ^ hist[i];
    end
    dout = (P_DESCRAMBLE_EN != 0) ? descr : din;
    s_d  = en ? din[63:64-SCR_TAP_B] : s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '1;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/rx_block_descrambler.sv
// ----------------------------------------------------------------------------
// rx_block_descrambler
// Assembles two 32-bit gearbox words into one 66-bit block (2-bit sync header
// plus 64-bit payload), descrambles the payload and checks the header.
//   clk, rst        rising-edge clock, synchronous active-high reset
//   data_i[31:0]    scrambled payload word
//   head_i[1:0]     sync header, meaningful with head_valid_i
//   head_valid_i    marks the first word of a block
//   data_valid_i    qualifies data_i/head_valid_i; low cycles are ignored
//   locked_i        block lock; while low no block is assembled
//   clr_cnt_i       synchronous clear of hdr_err_cnt_o (wins over increment)
//   blk_data_o      descrambled block, held between strobes
//   blk_head_o      block sync header, held between strobes
//   blk_valid_o     one-cycle strobe, one cycle after the second word
//   blk_hdr_err_o   with blk_valid_o when the header is 00 or 11
//   align_err_o     one-cycle pulse when a partial block is discarded
//   hdr_err_cnt_o   saturating header-error count
//
// Handshake: a word is accepted on a rising edge where data_valid_i and
// locked_i are both high; there is no back-pressure. Output strobes are valid
// for exactly the one cycle they are high.
// ----------------------------------------------------------------------------
module rx_block_descrambler
  import rx_pcs_pkg::*;
#(
  parameter int P_DESCRAMBLE_EN = 1,
  parameter int P_CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            data_i,
  input  logic [1:0]             head_i,
  input  logic                   head_valid_i,
  input  logic                   data_valid_i,
  input  logic                   locked_i,
  input  logic                   clr_cnt_i,
  output logic [63:0]            blk_data_o,
  output logic [1:0]             blk_head_o,
  output logic                   blk_valid_o,
  output logic                   blk_hdr_err_o,
  output logic                   align_err_o,
  output logic [P_CNT_WIDTH-1:0] hdr_err_cnt_o
);

  asm_state_e             state_q, state_d;
  logic [31:0]            lo_q, lo_d;
  logic [1:0]             hd_q, hd_d;
  logic [63:0]            blk_data_q, blk_data_d;
  logic [1:0]             blk_head_q, blk_head_d;
  logic                   blk_valid_q, blk_valid_d;
  logic                   blk_hdr_err_q, blk_hdr_err_d;
  logic                   align_err_q, align_err_d;
  logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        complete;
  logic [63:0] descr_out;

  assign accept   = locked_i & data_valid_i;
  assign complete = accept & (state_q == WAIT_SECOND) & ~head_valid_i;

  // The second word sits directly on din so the block is descrambled in the
  // cycle it completes; the state advances only on that same edge.
  pcs_descrambler_64 #(
    .P_DESCRAMBLE_EN (P_DESCRAMBLE_EN)
  ) u_descr (
    .clk  (clk),
    .rst  (rst),
    .en   (complete),
    .din  ({data_i, lo_q}),
    .dout (descr_out)
  );

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hd_d          = hd_q;
    blk_data_d    = blk_data_q;
    blk_head_d    = blk_head_q;
    blk_valid_d   = 1'b0;
    blk_hdr_err_d = 1'b0;
    align_err_d   = 1'b0;
    cnt_d         = cnt_q;

    if (!locked_i) begin
      // Loss of lock drops any partial block silently.
      state_d = WAIT_FIRST;
    end else if (accept) begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (head_valid_i) begin
            lo_d    = data_i;
            hd_d    = head_i;
            state_d = WAIT_SECOND;
          end
        end
        WAIT_SECOND: begin
          if (head_valid_i) begin
            // New block started early: restart assembly on this word.
            align_err_d = 1'b1;
            lo_d        = data_i;
            hd_d        = head_i;
          end else begin
            state_d = WAIT_FIRST;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end

    if (complete) begin
      blk_valid_d   = 1'b1;
      blk_data_d    = descr_out;
      blk_head_d    = hd_q;
      blk_hdr_err_d = hdr_is_bad(hd_q);
    end

    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (blk_hdr_err_d && (cnt_q != {P_CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_FIRST;
      lo_q          <= '0;
      hd_q          <= '0;
      blk_data_q    <= '0;
      blk_head_q    <= '0;
      blk_valid_q   <= 1'b0;
      blk_hdr_err_q <= 1'b0;
      align_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hd_q          <= hd_d;
      blk_data_q    <= blk_data_d;
      blk_head_q    <= blk_head_d;
      blk_valid_q   <= blk_valid_d;
      blk_hdr_err_q <= blk_hdr_err_d;
      align_err_q   <= align_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign blk_data_o    = blk_data_q;
  assign blk_head_o    = blk_head_q;
  assign blk_valid_o   = blk_valid_q;
  assign blk_hdr_err_o = blk_hdr_err_q;
  assign align_err_o   = align_err_q;
  assign hdr_err_cnt_o = cnt_q;

endmodule

// File: tb/tb_rx_block_descrambler.sv
module tb_rx_block_descrambler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] data_i;
  logic [1:0]  head_i;
  logic        head_valid_i;
  logic        data_valid_i;
  logic        locked_i;
  logic        clr_cnt_i;

  logic [63:0] blk_data_o,    raw_data_o,    c4_data_o;
  logic [1:0]  blk_head_o,    raw_head_o,    c4_head_o;
  logic        blk_valid_o,   raw_valid_o,   c4_valid_o;
  logic        blk_hdr_err_o, raw_hdr_err_o, c4_hdr_err_o;
  logic        align_err_o,   raw_align_o,   c4_align_o;
  logic [15:0] hdr_err_cnt_o, raw_cnt_o;
  logic [3:0]  c4_cnt_o;

  rx_block_descrambler dut (
    .clk(clk), .rst(rst), .data_i(data_i), .head_i(head_i),
    .head_valid_i(head_valid_i), .data_valid_i(data_valid_i),
    .locked_i(locked_i), .clr_cnt_i(clr_cnt_i),
    .blk_data_o(blk_data_o), .blk_head_o(blk_head_o), .blk_valid_o(blk_valid_o),
    .blk_hdr_err_o(blk_hdr_err_o), .align_err_o(align_err_o),
    .hdr_err_cnt_o(hdr_err_cnt_o)
  );

  rx_block_descrambler #(.P_DESCRAMBLE_EN(0)) dut_raw (
    .clk(clk), .rst(rst), .data_i(data_i), .head_i(head_i),
    .head_valid_i(head_valid_i), .data_valid_i(data_valid_i),
    .locked_i(locked_i), .clr_cnt_i(clr_cnt_i),
    .blk_data_o(raw_data_o), .blk_head_o(raw_head_o), .blk_valid_o(raw_valid_o),
    .blk_hdr_err_o(raw_hdr_err_o), .align_err_o(raw_align_o),
    .hdr_err_cnt_o(raw_cnt_o)
  );

  rx_block_descrambler #(.P_CNT_WIDTH(4)) dut_c4 (
    .clk(clk), .rst(rst), .data_i(data_i), .head_i(head_i),
    .head_valid_i(head_valid_i), .data_valid_i(data_valid_i),
    .locked_i(locked_i), .clr_cnt_i(clr_cnt_i),
    .blk_data_o(c4_data_o), .blk_head_o(c4_head_o), .blk_valid_o(c4_valid_o),
    .blk_hdr_err_o(c4_hdr_err_o), .align_err_o(c4_align_o),
    .hdr_err_cnt_o(c4_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int exp_cnt  = 0;
  int exp_cnt4 = 0;
  logic [63:0] last_plain;
  logic [1:0]  last_head;

  // Reference line history: one entry per scrambled bit that reached the
  // descrambler in a completed block, oldest first, always 58 long.
  bit hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < 58; k++) hist.push_back(1'b1);
  endtask

  // Serial x^58+x^39+1: bit t uses line bits t-39 and t-58.
  task automatic model_descramble(input logic [63:0] scr, output logic [63:0] plain);
    for (int i = 0; i < 64; i++) begin
      plain[i] = scr[i] ^ hist[58 - 39] ^ hist[0];
      hist.push_back(scr[i]);
      void'(hist.pop_front());
    end
  endtask

  task automatic model_scramble(input logic [63:0] plain, output logic [63:0] scr);
    for (int i = 0; i < 64; i++) begin
      scr[i] = plain[i] ^ hist[58 - 39] ^ hist[0];
      hist.push_back(scr[i]);
      void'(hist.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic hv, input logic [1:0] hd, input logic [31:0] d);
    data_valid_i = v;
    head_valid_i = hv;
    head_i       = hd;
    data_i       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 2'b11, $urandom);
  endtask

  // Sends one block and checks the strobe cycle against the scoreboard.
  task automatic send_block(input logic [63:0] scr, input logic [1:0] hd, input int gap,
                            input logic clr, input logic [63:0] exp_plain);
    logic bad;
    drive(1'b1, 1'b1, hd, scr[31:0]);
    check("first_word_no_strobe", {63'd0, blk_valid_o}, 64'd0);
    for (int g = 0; g < gap; g++) begin
      idle();
      check("gap_no_strobe", {63'd0, blk_valid_o}, 64'd0);
    end
    clr_cnt_i = clr;
    drive(1'b1, 1'b0, 2'b11, scr[63:32]);
    clr_cnt_i = 1'b0;
    bad = (hd == 2'b00) || (hd == 2'b11);
    if (clr) begin
      exp_cnt = 0; exp_cnt4 = 0;
    end else if (bad) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    exp_q.push_back(exp_plain);
    check("blk_valid", {63'd0, blk_valid_o}, 64'd1);
    check("blk_data", blk_data_o, exp_q.pop_front());
    check("blk_head", {62'd0, blk_head_o}, {62'd0, hd});
    check("blk_hdr_err", {63'd0, blk_hdr_err_o}, {63'd0, bad});
    check("align_quiet", {63'd0, align_err_o}, 64'd0);
    check("raw_data", raw_data_o, scr);
    check("hdr_cnt", {48'd0, hdr_err_cnt_o}, 64'(exp_cnt));
    check("hdr_cnt4", {60'd0, c4_cnt_o}, 64'(exp_cnt4));
    last_plain = exp_plain;
    last_head  = hd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] scr, plain, payload;
    logic [1:0]  hd;
    logic [31:0] w;

    rst = 1'b1; locked_i = 1'b0; clr_cnt_i = 1'b0;
    data_valid_i = 1'b0; head_valid_i = 1'b0; head_i = 2'b00; data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", blk_data_o, 64'd0);
    check("rst_head", {62'd0, blk_head_o}, 64'd0);
    check("rst_valid", {63'd0, blk_valid_o}, 64'd0);
    check("rst_hdr_err", {63'd0, blk_hdr_err_o}, 64'd0);
    check("rst_align", {63'd0, align_err_o}, 64'd0);
    check("rst_cnt", {48'd0, hdr_err_cnt_o}, 64'd0);
    rst = 1'b0; locked_i = 1'b1;
    idle();

    // All-zero line after reset exposes the all-ones seed.
    model_descramble(64'd0, plain);
    send_block(64'd0, 2'b01, 0, 1'b0, plain);
    check("zero_blk1_const", blk_data_o, 64'h03FF_FF80_0000_0000);
    model_descramble(64'd0, plain);
    send_block(64'd0, 2'b01, 0, 1'b0, plain);
    check("zero_blk2_const", blk_data_o, 64'd0);

    // Outputs hold between strobes.
    idle();
    check("hold_valid", {63'd0, blk_valid_o}, 64'd0);
    check("hold_data", blk_data_o, last_plain);
    check("hold_head", {62'd0, blk_head_o}, {62'd0, last_head});

    // Pause cycles between the two words.
    payload = {$urandom, $urandom};
    model_scramble(payload, scr);
    send_block(scr, 2'b10, 2, 1'b0, payload);

    // Two headers in a row: the second restarts the block.
    w = $urandom;
    drive(1'b1, 1'b1, 2'b01, w);
    payload = {$urandom, $urandom};
    model_scramble(payload, scr);
    drive(1'b1, 1'b1, 2'b10, scr[31:0]);
    check("align_pulse", {63'd0, align_err_o}, 64'd1);
    check("align_no_strobe", {63'd0, blk_valid_o}, 64'd0);
    drive(1'b1, 1'b0, 2'b00, scr[63:32]);
    check("realign_valid", {63'd0, blk_valid_o}, 64'd1);
    check("realign_data", blk_data_o, payload);
    check("realign_head", {62'd0, blk_head_o}, 64'd2);
    check("align_single", {63'd0, align_err_o}, 64'd0);

    // Header errors, clear coincident with the second one.
    payload = {$urandom, $urandom};
    model_scramble(payload, scr);
    send_block(scr, 2'b00, 0, 1'b0, payload);
    payload = {$urandom, $urandom};
    model_scramble(payload, scr);
    send_block(scr, 2'b11, 1, 1'b1, payload);
    idle();
    check("hdr_err_pulse_end", {63'd0, blk_hdr_err_o}, 64'd0);
    for (int n = 0; n < 20; n++) begin
      payload = {$urandom, $urandom};
      model_scramble(payload, scr);
      send_block(scr, (n % 2 == 0) ? 2'b00 : 2'b11, 0, 1'b0, payload);
    end
    check("cnt4_saturated", {60'd0, c4_cnt_o}, 64'hF);
    check("cnt16_twenty", {48'd0, hdr_err_cnt_o}, 64'd20);

    // Lock drops mid-block; nothing may come out until a fresh block.
    drive(1'b1, 1'b1, 2'b01, $urandom);
    locked_i = 1'b0;
    drive(1'b1, 1'b0, 2'b01, $urandom);
    check("unlock_no_strobe", {63'd0, blk_valid_o}, 64'd0);
    drive(1'b1, 1'b1, 2'b01, $urandom);
    drive(1'b1, 1'b0, 2'b01, $urandom);
    check("unlock_no_strobe2", {63'd0, blk_valid_o}, 64'd0);
    locked_i = 1'b1;
    drive(1'b1, 1'b0, 2'b01, $urandom);
    check("relock_orphan_dropped", {63'd0, blk_valid_o}, 64'd0);
    check("relock_no_align", {63'd0, align_err_o}, 64'd0);
    payload = {$urandom, $urandom};
    model_scramble(payload, scr);
    send_block(scr, 2'b01, 0, 1'b0, payload);

    // Reset mid-block: no strobe, no alignment error, state reseeded.
    drive(1'b1, 1'b1, 2'b10, $urandom);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    model_reset();
    exp_cnt = 0; exp_cnt4 = 0;
    check("midrst_valid", {63'd0, blk_valid_o}, 64'd0);
    check("midrst_align", {63'd0, align_err_o}, 64'd0);
    check("midrst_data", blk_data_o, 64'd0);
    drive(1'b1, 1'b0, 2'b01, $urandom);
    check("midrst_orphan", {63'd0, blk_valid_o}, 64'd0);
    check("midrst_orphan_align", {63'd0, align_err_o}, 64'd0);
    payload = {$urandom, $urandom};
    model_scramble(payload, scr);
    send_block(scr, 2'b01, 0, 1'b0, payload);

    // Random traffic through the reference scrambler.
    for (int b = 0; b < 1000; b++) begin
      payload = {$urandom, $urandom};
      hd = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      model_scramble(payload, scr);
      send_block(scr, hd, $urandom_range(0, 2), 1'b0, payload);
      if ($urandom_range(0, 3) == 0) idle();
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
